ap_acc_seq: RTL and testbench

- Sequencer that drives one W-bit signed saturating adder to reduce a stream of operands to a single sum.
- Typical use: RBM neuron pre-activation, the sum of weight×state products.
- Accepts a job (start + length), consumes `len` operands over a valid/ready stream and accumulates them with saturation.
- Presents the result on a valid/ready output port, with a sticky saturation flag.
- Sits between the product generator and the activation/sigmoid stage.

---
 rtl/ap_acc_seq.sv | 118 +++++++++++
 tb/tb_ap_acc_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_acc_seq.sv
// Saturating accumulate sequencer: reduces a len-operand valid/ready stream to one signed sum.
// Optional macro AP_ACC_BIAS_EN adds a bias port that seeds the accumulator at job start.

module ap_adder #(
    parameter int W = 68
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);
    assign sum = a + b;
endmodule

module ap_acc_seq #(
    parameter int W     = 68,
    parameter int LEN_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_sat
`ifdef AP_ACC_BIAS_EN
    ,
    input  logic signed [W-1:0] bias
`endif
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

    logic [1:0]       state;
    logic [W-1:0]     acc;
    logic [LEN_W-1:0] cnt;
    logic             sat;

    logic [W-1:0] sum_raw;
    logic [W-1:0] sum_sat;
    logic         pos_ovf;
    logic         neg_ovf;
    logic [W-1:0] acc_init;

    ap_adder #(.W(W)) u_add (
        .a   (acc),
        .b   (in_data),
        .sum (sum_raw)
    );

    // Overflow only possible when both operands share a sign and the result flips it.
    assign pos_ovf = ~acc[W-1] & ~in_data[W-1] &  sum_raw[W-1];
    assign neg_ovf =  acc[W-1] &  in_data[W-1] & ~sum_raw[W-1];

    always_comb begin
        sum_sat = sum_raw;
        if (pos_ovf)
            sum_sat = SMAX;
        else if (neg_ovf)
            sum_sat = SMIN;
    end

`ifdef AP_ACC_BIAS_EN
    assign acc_init = bias;
`else
    assign acc_init = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= acc_init;
                        sat   <= 1'b0;
                        cnt   <= len;
                        state <= (len == '0) ? S_DONE : S_ACC;
                    end
                end
                S_ACC: begin
                    if (in_valid) begin
                        acc <= sum_sat;
                        sat <= sat | pos_ovf | neg_ovf;
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1))
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // acc/sat only change on job start or transfer, so they hold the last result through IDLE.
    assign out_data  = acc;
    assign out_sat   = sat;
    assign out_valid = (state == S_DONE);
    assign in_ready  = (state == S_ACC);
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_ap_acc_seq.sv
// Randomized self-checking bench for ap_acc_seq against a wide-arithmetic clamp model.
// Bias tests run only when AP_ACC_BIAS_EN is defined.

module tb_ap_acc_seq;
    localparam int W     = 68;
    localparam int LEN_W = 16;

    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic [LEN_W-1:0]    len = '0;
    logic                busy;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic signed [W-1:0] out_data;
    logic                out_sat;
    logic signed [W-1:0] bias = '0;

    int total = 0;
    int bad   = 0;

    logic signed [W-1:0] ops[$];
    bit                  vpat[$];

    ap_acc_seq #(.W(W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef AP_ACC_BIAS_EN
        ,
        .bias      (bias)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Exact sum in two extra bits, then clamp to the W-bit signed range.
    function automatic logic signed [W-1:0] ref_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b,
                                                    output bit o);
        logic signed [W+1:0] s, hi, lo;
        s  = a;
        s  = s + b;
        hi = MAXV;
        lo = MINV;
        o  = 1'b0;
        if (s > hi) begin
            o = 1'b1;
            return MAXV;
        end
        if (s < lo) begin
            o = 1'b1;
            return MINV;
        end
        return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] rnd_op();
        logic [95:0] r;
        logic signed [31:0] sm;
        r  = {$urandom, $urandom, $urandom};
        sm = $urandom;
        case ($urandom_range(3))
            0: return W'(sm);
            1: return MAXV - W'($urandom_range(1000));
            2: return MINV + W'($urandom_range(1000));
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic run_job(input int n, input int vpct, input int hold, input logic signed [W-1:0] b);
        logic signed [W-1:0] m_acc;
        bit m_sat, o;
        int sent, cyc;
        bias  = b;
        len   = LEN_W'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef AP_ACC_BIAS_EN
        m_acc = b;
`else
        m_acc = '0;
`endif
        m_sat = 1'b0;
        sent  = 0;
        cyc   = 0;
        while (sent < n && cyc < 400) begin
            chk("in_ready_acc", in_ready, 1);
            if (vpat.size() > 0)
                in_valid = vpat[cyc % vpat.size()];
            else
                in_valid = ($urandom_range(99) < vpct);
            in_data = ops[sent];
            start   = ($urandom_range(3) == 0);
            @(posedge clk);
            if (in_valid) begin
                m_acc = ref_add(m_acc, ops[sent], o);
                m_sat = m_sat | o;
                sent++;
            end
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (sent < n)
            chk("transfer_timeout", sent, n);
        chk("out_valid_latency", out_valid, 1);
        for (int i = 0; i < hold; i++) begin
            start = ($urandom_range(1) == 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, m_acc);
            chk("hold_sat", out_sat, m_sat);
            chk("hold_busy", busy, 1);
            chk("hold_in_ready", in_ready, 0);
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("out_data", out_data, m_acc);
        chk("out_sat", out_sat, m_sat);
        tick();
        out_ready = 1'b0;
        chk("idle_valid", out_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_data_hold", out_data, m_acc);
    endtask

    initial begin
        logic signed [W-1:0] p66;
        p66 = 1;
        p66 = p66 <<< 66;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);

        ops = '{W'(5), -W'(2), W'(10)};
        run_job(3, 100, 0, '0);
        chk("basic_sum_13", out_data, W'(13));
        tick();

        ops = '{p66, p66, p66};
        run_job(3, 100, 0, '0);
        chk("pos_sat_max", out_data, MAXV);
        tick();
        ops = '{p66, p66, p66, -W'(1)};
        run_job(4, 100, 0, '0);
        chk("pos_sat_minus1", out_data, MAXV - 1);
        chk("pos_sat_flag", out_sat, 1);
        tick();

        ops = '{MINV, -W'(1)};
        run_job(2, 100, 0, '0);
        chk("neg_sat_min", out_data, MINV);
        tick();

        ops  = '{W'(3), W'(4), -W'(9), W'(100)};
        vpat = '{1, 0, 0, 1, 1, 0, 1};
        run_job(4, 0, 5, '0);
        vpat.delete();
        tick();

        ops.delete();
        run_job(0, 100, 2, '0);
        chk("len0_data", out_data, 0);
        tick();

        // Reset after two of five operands: job must vanish.
        ops   = '{W'(11), W'(22), W'(33), W'(44), W'(55)};
        len   = LEN_W'(5);
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = ops[0];
        tick();
        in_data  = ops[1];
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_data", out_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("midrst_no_result", out_valid, 0);
        end
        ops = '{W'(7)};
        run_job(1, 100, 0, '0);
        chk("after_rst_7", out_data, W'(7));
        chk("after_rst_sat", out_sat, 0);
        tick();

`ifdef AP_ACC_BIAS_EN
        ops = '{W'(30), W'(40)};
        run_job(2, 100, 0, -W'(100));
        chk("bias_neg30", out_data, -W'(30));
        tick();
        ops = '{W'(1)};
        run_job(1, 100, 0, MAXV);
        chk("bias_sat", out_sat, 1);
        tick();
        ops.delete();
        run_job(0, 100, 0, W'(12345));
        tick();
`endif

        for (int j = 0; j < 30; j++) begin
            int n;
            n = $urandom_range(12);
            ops.delete();
            for (int k = 0; k < n; k++)
                ops.push_back(rnd_op());
            run_job(n, 30 + $urandom_range(70), $urandom_range(3), rnd_op());
            if ($urandom_range(1) == 0)
                tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
